// File: rtl/div_pkg.sv
// Shared encodings for the RV32M iterative divider: FSM states, SELECT codes
// and the RISC-V special-result constants.
package div_pkg;

  localparam int DIV_XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  localparam logic [4:0] SEL_ADD  = 5'd0;
  localparam logic [4:0] SEL_DIV  = 5'd12;
  localparam logic [4:0] SEL_DIVU = 5'd13;
  localparam logic [4:0] SEL_REM  = 5'd14;
  localparam logic [4:0] SEL_REMU = 5'd15;

  localparam logic [DIV_XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [DIV_XLEN-1:0] INT_MIN  = 32'h8000_0000;

  function automatic logic is_div_sel(input logic [4:0] sel);
    return (sel == SEL_DIV) || (sel == SEL_DIVU) || (sel == SEL_REM) || (sel == SEL_REMU);
  endfunction

  function automatic logic is_signed_sel(input logic [4:0] sel);
    return (sel == SEL_DIV) || (sel == SEL_REM);
  endfunction

  function automatic logic is_rem_sel(input logic [4:0] sel);
    return (sel == SEL_REM) || (sel == SEL_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quot} left by one, trial-subtract
// the divisor and keep the difference when it is non-negative.
module div_step
  import div_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic [XLEN:0]   rem_in,
  input  logic [XLEN-1:0] quot_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_out,
  output logic [XLEN-1:0] quot_out
);

  logic [XLEN:0] shifted;
  logic          ge;

  // The shifted-out MSB of rem_in makes the partial remainder at least 2^(XLEN+1).
  always_comb begin
    shifted  = {rem_in[XLEN-1:0], quot_in[XLEN-1]};
    ge       = rem_in[XLEN] | (shifted >= {1'b0, divisor});
    rem_out  = shifted;
    quot_out = {quot_in[XLEN-2:0], 1'b0};
    if (ge) begin
      rem_out  = shifted - {1'b0, divisor};
      quot_out = {quot_in[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU) with IDLE/CALC/FIN FSM.
// Define DIV_FAST_PATH_EN to send divide-by-zero, overflow and unsigned a<b straight to FIN.
module div_unit
  import div_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            START,
  input  logic [4:0]      SELECT,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic            FLUSH,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  localparam int CNT_W = $clog2(XLEN);

  state_e            state_q, state_d;
  logic              rem_sel_q, rem_sel_d;
  logic              neg_quot_q, neg_quot_d;
  logic              neg_rem_q, neg_rem_d;
  logic              div_zero_q, div_zero_d;
  logic              ovf_q, ovf_d;
  logic [XLEN-1:0]   quot_q, quot_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic [XLEN-1:0]   divisor_q, divisor_d;
  logic [XLEN-1:0]   dividend_q, dividend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              done_q, done_d;

  logic [XLEN:0]     step_rem;
  logic [XLEN-1:0]   step_quot;
  logic              sel_signed;
  logic              start_zero;
  logic              start_ovf;
  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem_q),
    .quot_in (quot_q),
    .divisor (divisor_q),
    .rem_out (step_rem),
    .quot_out(step_quot)
  );

  always_comb begin
    sel_signed = is_signed_sel(SELECT);
    start_zero = (DATA2 == '0);
    start_ovf  = sel_signed && (DATA1 == INT_MIN) && (DATA2 == ALL_ONES);
    abs_a      = (sel_signed && DATA1[XLEN-1]) ? -DATA1 : DATA1;
    abs_b      = (sel_signed && DATA2[XLEN-1]) ? -DATA2 : DATA2;
    quot_fix   = neg_quot_q ? -quot_q : quot_q;
    rem_fix    = neg_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
  end

  always_comb begin
    state_d    = state_q;
    rem_sel_d  = rem_sel_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    ovf_d      = ovf_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    divisor_d  = divisor_q;
    dividend_d = dividend_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    done_d     = 1'b0;

    if (FLUSH) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (START && is_div_sel(SELECT)) begin
            state_d    = ST_CALC;
            rem_sel_d  = is_rem_sel(SELECT);
            neg_quot_d = sel_signed && (DATA1[XLEN-1] ^ DATA2[XLEN-1]);
            neg_rem_d  = sel_signed && DATA1[XLEN-1];
            div_zero_d = start_zero;
            ovf_d      = start_ovf;
            quot_d     = abs_a;
            divisor_d  = abs_b;
            dividend_d = DATA1;
            rem_d      = '0;
            cnt_d      = '0;
`ifdef DIV_FAST_PATH_EN
            if (start_zero || start_ovf) begin
              state_d = ST_FIN;
            end else if (!sel_signed && (DATA1 < DATA2)) begin
              // Quotient 0 and remainder DATA1 fall out of the normal FIN correction.
              state_d = ST_FIN;
              quot_d  = '0;
              rem_d   = {1'b0, DATA1};
            end
`endif
          end
        end
        ST_CALC: begin
          quot_d = step_quot;
          rem_d  = step_rem;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            state_d = ST_FIN;
          end
        end
        ST_FIN: begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          // RISC-V defined results override whatever the iterations produced.
          if (div_zero_q) begin
            result_d = rem_sel_q ? dividend_q : ALL_ONES;
          end else if (ovf_q) begin
            result_d = rem_sel_q ? '0 : INT_MIN;
          end else begin
            result_d = rem_sel_q ? rem_fix : quot_fix;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      rem_sel_q  <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      divisor_q  <= '0;
      dividend_q <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_sel_q  <= rem_sel_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      ovf_q      <= ovf_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      divisor_q  <= divisor_d;
      dividend_q <= dividend_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      done_q     <= done_d;
    end
  end

  assign BUSY   = (state_q != ST_IDLE);
  assign DONE   = done_q;
  assign RESULT = result_q;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
Multi-cycle iterative divider for the RV32M divide group (DIV, DIVU, REM, REMU) in the EX stage.
- The EX stage issues a request with a START pulse and waits; this unit answers with a one-cycle DONE pulse and a held RESULT.
- The single-cycle ALU path is unchanged. This unit replaces its combinational divide so that divides no longer sit on the critical path.
- BUSY drives the pipeline stall logic.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.

Ports:
CLK  input  1  clock; all state changes on the rising edge.
RESET_N  input  1  asynchronous, active-low reset.
START  input  1  request strobe; sampled only in IDLE.
SELECT  input  5  operation code; shared `DIV/`DIVU/`REM/`REMU encodings.
DATA1  input  XLEN  dividend; sampled with START.
DATA2  input  XLEN  divisor; sampled with START.
FLUSH  input  1  synchronous abort (branch/exception flush).
BUSY  output  1  high in CALC and FIN states.
DONE  output  1  one-cycle completion pulse.
RESULT  output  XLEN  quotient or remainder; held until the next completion.

Behaviour:
- Reset (RESET_N low, asynchronous): state=IDLE; BUSY=0, DONE=0, RESULT=0; all internal registers cleared. An aborted operation never produces DONE.
- States: IDLE, CALC, FIN.
- IDLE -> CALC at edge N when START=1 and SELECT is one of the four divide codes.
  - Latch the op and operand signs.
  - Load |DATA1| and |DATA2| for signed ops, raw values for unsigned ops.
  - Clear the remainder and set the iteration count to 0.
- START with any other SELECT is ignored (stay in IDLE, no DONE).
- CALC: one restoring-division step per edge, MSB first.
  - Shift {rem, quot} left by 1, trial-subtract the divisor, set the quotient bit if the result is non-negative.
  - The remainder register is XLEN+1 bits wide.
  - The step at edge N+32 is the 32nd; it moves the state to FIN.
- FIN -> IDLE at edge N+33.
  - Apply sign correction: quotient negated if the operand signs differ; remainder takes the dividend's sign.
  - Register RESULT (quotient for DIV/DIVU, remainder for REM/REMU) and assert DONE for exactly the following cycle.
- Latency: DONE is high in the cycle after edge N+33. BUSY=1 from after edge N through edge N+33.
- Back-to-back: START sampled in the DONE cycle (state already IDLE) is accepted. DONE then drops at the next edge.
- START while BUSY is ignored; the operand latches do not change.
- FLUSH=1 at any edge forces IDLE with no DONE. RESULT keeps its previous value. FLUSH has priority over START in the same cycle.
- Special results (RISC-V defined):
  - Divisor 0: DIV/DIVU = 0xFFFFFFFF; REM/REMU = DATA1.
  - DIV 0x80000000 / 0xFFFFFFFF = 0x80000000; REM of the same operands = 0.
  - Without the fast path, these still take the full 34 edges. The FIN stage substitutes the values; the iteration data is discarded.

Optional Feature:
DIV_FAST_PATH_EN
- Defined: divisor-zero and signed-overflow cases go IDLE -> FIN directly, so DONE appears in the cycle after edge N+1. Unsigned cases with DATA1 < DATA2 also take this path: quotient 0, remainder DATA1.
- Undefined: every accepted op takes exactly 34 edges. The fixed latency suits a static-stall scheduler.

Decomposition:
- Shared encodings header (package): state codes, the `DIV/`DIVU/`REM/`REMU select codes, and the special constants 0xFFFFFFFF and 0x80000000.
- Sub-module div_step: combinational single-iteration shift/trial-subtract. Takes rem_in, quot_in, divisor; returns rem_out, quot_out.

Test Plan:
1. DIVU 100 / 7: START at edge N -> BUSY high, DONE in the cycle after edge N+33, RESULT=14. REMU same operands -> RESULT=2.
2. DIV -7 / 2 -> RESULT=0xFFFFFFFD (-3). REM -7 / 2 -> RESULT=0xFFFFFFFF (-1).
3. DIV 5 / 0 -> 0xFFFFFFFF. REM 5 / 0 -> 5. DIV 0x80000000 / -1 -> 0x80000000, REM -> 0. Latency is 34 edges without DIV_FAST_PATH_EN, and DONE follows edge N+1 with it.
4. FLUSH at edge N+10 -> state IDLE, BUSY=0, no DONE, RESULT keeps its prior value. RESET_N low mid-CALC -> all outputs 0 immediately.
5. Back-to-back: second START (DIVU 9/3) in the DONE cycle of the first op -> accepted; its DONE follows 34 edges later with RESULT=3. A START pulsed while BUSY is ignored.
6. START with SELECT=`ADD -> stays IDLE, BUSY=0, no DONE.
